player_motion_ctrl: RTL

- Sequences board-game moves for the two Kirby sprites: converts "move player P by N tiles" into per-frame pixel positions with a hop arc.
- Sits between game logic and the sprite renderer; drives each player's player_x/player_y (10-bit screen coordinates; sprite is 16x16, drawn at top-left).
- Serialises moves: one player animates at a time; the other stays parked on its tile.

---
 rtl/player_motion_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: turns "move player P by N tiles" into per-frame sprite
// positions with a hop arc. One player animates at a time; the other stays parked.
module player_motion_ctrl #(
  parameter int BASE_X     = 32,
  parameter int BASE_Y     = 200,
  parameter int LANE_DY    = 20,
  parameter int TILE_W     = 32,
  parameter int NUM_TILES  = 16,
  parameter int HOP_FRAMES = 8,
  parameter int HOP_LIFT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       move_req,
  input  logic       move_player,
  input  logic [3:0] move_steps,
  output logic       move_ack,
  output logic       busy,
  output logic       done,
  output logic [9:0] p0_x,
  output logic [9:0] p1_x,
  output logic [9:0] p0_y,
  output logic [9:0] p1_y,
  output logic [3:0] p0_tile,
  output logic [3:0] p1_tile,
  output logic       p0_goal,
  output logic       p1_goal
);

  localparam int         FW        = $clog2(HOP_FRAMES + 1);
  localparam logic [3:0] LAST_TILE = 4'(NUM_TILES - 1);
  localparam logic [9:0] STEP_X    = 10'(TILE_W / HOP_FRAMES);
  localparam logic [9:0] LANE0     = 10'(BASE_Y);
  localparam logic [9:0] LANE1     = 10'(BASE_Y + LANE_DY);
  localparam logic [9:0] HOME_X    = 10'(BASE_X);

  typedef enum logic [1:0] {IDLE, HOP, FIN} state_t;

  state_t        state;
  logic          active;
  logic [FW-1:0] f;
  logic [3:0]    steps_left;

  logic [3:0]    cur_tile;
  logic [9:0]    cur_x;
  logic [9:0]    lane;
  logic [FW-1:0] f_inc;
  logic [FW-1:0] f_dist;
  logic [FW-1:0] arc_min;
  logic [9:0]    arc_y;
  logic [3:0]    land_tile;
  logic [9:0]    land_x;
  logic [3:0]    req_tile;
  logic [3:0]    room;
  logic [3:0]    steps_eff;

  // Active-player view, hop arc for the next frame, and truncated request length
  always_comb begin
    cur_tile  = active ? p1_tile : p0_tile;
    cur_x     = active ? p1_x : p0_x;
    lane      = active ? LANE1 : LANE0;
    f_inc     = f + FW'(1);
    f_dist    = FW'(HOP_FRAMES) - f_inc;
    arc_min   = (f_inc < f_dist) ? f_inc : f_dist;
    arc_y     = lane - 10'(HOP_LIFT) * 10'(arc_min);
    land_tile = cur_tile + 4'd1;
    land_x    = HOME_X + 10'(land_tile) * 10'(TILE_W);
    req_tile  = move_player ? p1_tile : p0_tile;
    room      = LAST_TILE - req_tile;
    steps_eff = (move_steps < room) ? move_steps : room;
  end

  // Move sequencer: accepts requests, advances the hop per frame, pulses done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      active     <= 1'b0;
      f          <= '0;
      steps_left <= '0;
      move_ack   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      p0_tile    <= '0;
      p1_tile    <= '0;
      p0_x       <= HOME_X;
      p1_x       <= HOME_X;
      p0_y       <= LANE0;
      p1_y       <= LANE1;
    end else begin
      move_ack <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (move_req) begin
            move_ack   <= 1'b1;
            busy       <= 1'b1;
            active     <= move_player;
            f          <= '0;
            steps_left <= steps_eff;
            state      <= (steps_eff == 4'd0) ? FIN : HOP;
          end
        end
        HOP: begin
          if (frame_tick) begin
            if (f == FW'(HOP_FRAMES - 1)) begin
              // Landing snaps to the exact tile position so per-frame steps never drift
              if (active) begin
                p1_tile <= land_tile;
                p1_x    <= land_x;
                p1_y    <= lane;
              end else begin
                p0_tile <= land_tile;
                p0_x    <= land_x;
                p0_y    <= lane;
              end
              f          <= '0;
              steps_left <= steps_left - 4'd1;
              if (steps_left == 4'd1) state <= FIN;
            end else begin
              f <= f_inc;
              if (active) begin
                p1_x <= cur_x + STEP_X;
                p1_y <= arc_y;
              end else begin
                p0_x <= cur_x + STEP_X;
                p0_y <= arc_y;
              end
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_goal = (p0_tile == LAST_TILE);
  assign p1_goal = (p1_tile == LAST_TILE);

endmodule
